// File: rtl/shift_add_mult_pkg.sv
// Shared types and derived-size helpers for the sequential shift-and-add multiplier.
package shift_add_mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic int calc_cyc(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic int calc_ow(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  function automatic bit bpc_legal(input int width, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/mult_step_unit.sv
// One shift-and-add step: adds multiplicand * BPC multiplier bits at the top of the
// partial product, then shifts the whole thing right by BPC.
module mult_step_unit #(
  parameter int WIDTH = 128,
  parameter int BPC   = 1
) (
  input  logic [2*WIDTH-1:0] partial,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [BPC-1:0]     bits,
  output logic [2*WIDTH-1:0] partial_nxt
);

  logic [WIDTH+BPC-1:0]   term;
  logic [WIDTH+BPC-1:0]   upper;
  logic [2*WIDTH+BPC-1:0] joined;

  // Upper half stays below 2^WIDTH between steps, so WIDTH+BPC bits hold the sum.
  assign term        = {{BPC{1'b0}}, mcand} * {{WIDTH{1'b0}}, bits};
  assign upper       = {{BPC{1'b0}}, partial[2*WIDTH-1:WIDTH]} + term;
  assign joined      = {upper, partial[WIDTH-1:0]};
  assign partial_nxt = joined[2*WIDTH+BPC-1:BPC];

endmodule

// File: rtl/shift_add_mult_pipe.sv
// Sequential signed/unsigned multiplier with optional accumulate, retiring BPC
// multiplier bits per cycle behind a ready/valid handshake.
module shift_add_mult_pipe
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int BPC   = 1,
  parameter int GUARD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [WIDTH-1:0]         in0,
  input  logic [WIDTH-1:0]         in1,
  input  logic                     signed_mode,
  input  logic                     acc_mode,
  output logic                     in_ready,
  output logic [2*WIDTH+GUARD-1:0] out,
  output logic                     valid,
  input  logic                     out_ready
);

  localparam int CYC = calc_cyc(WIDTH, BPC);
  localparam int OW  = calc_ow(WIDTH, GUARD);
  localparam int CW  = $clog2(CYC + 1);

  if (!bpc_legal(WIDTH, BPC)) begin : g_bpc_check
    $error("shift_add_mult_pipe: BPC must be 1, 2 or 4 and divide WIDTH");
  end

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mplier, mag0, mag1;
  logic [2*WIDTH-1:0] partial, partial_nxt, signed_prod;
  logic [CW-1:0]      count;
  logic               neg, sgn, acc, accept, last_step;
  logic [OW-1:0]      prod_ext;

  assign in_ready  = (state == IDLE);
  assign valid     = (state == DONE);
  assign accept    = load && in_ready;
  assign last_step = (state == BUSY) && (count == CW'(1));

  // Magnitudes: -min wraps to 2^(WIDTH-1), which is still correct as unsigned.
  assign mag0 = (signed_mode && in0[WIDTH-1]) ? -in0 : in0;
  assign mag1 = (signed_mode && in1[WIDTH-1]) ? -in1 : in1;

  mult_step_unit #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
    .partial    (partial),
    .mcand      (mcand),
    .bits       (mplier[BPC-1:0]),
    .partial_nxt(partial_nxt)
  );

  assign signed_prod = neg ? -partial_nxt : partial_nxt;
  assign prod_ext    = sgn ? OW'($signed(signed_prod)) : OW'(signed_prod);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (count == CW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      partial <= '0;
      count   <= '0;
      neg     <= 1'b0;
      sgn     <= 1'b0;
      acc     <= 1'b0;
      out     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand   <= mag0;
        mplier  <= mag1;
        neg     <= signed_mode && (in0[WIDTH-1] ^ in1[WIDTH-1]);
        sgn     <= signed_mode;
        acc     <= acc_mode;
        partial <= '0;
        count   <= CW'(CYC);
      end else if (state == BUSY) begin
        partial <= partial_nxt;
        mplier  <= mplier >> BPC;
        count   <= count - CW'(1);
        if (last_step) out <= (acc ? out : '0) + prod_ext;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_mult_pipe.sv
// Bench: three 8-bit instances (BPC 1/2/4) driven from a vector table and a few
// hand-written handshake, accumulate-wrap and reset sequences.
module tb_shift_add_mult_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in0 = '0, in1 = '0;
  logic        signed_mode = 1'b0, acc_mode = 1'b0, out_ready = 1'b1;
  logic [2:0]  load_v = '0;
  logic [2:0]  valid_v, in_ready_v;
  logic [19:0] out_v [3];

  int total = 0;
  int bad   = 0;
  logic [19:0] sb[$];

  always #5 clk = ~clk;

  shift_add_mult_pipe #(.WIDTH(8), .BPC(1), .GUARD(4)) u_b1 (
    .clk(clk), .rst(rst), .load(load_v[0]), .in0(in0), .in1(in1),
    .signed_mode(signed_mode), .acc_mode(acc_mode), .in_ready(in_ready_v[0]),
    .out(out_v[0]), .valid(valid_v[0]), .out_ready(out_ready));

  shift_add_mult_pipe #(.WIDTH(8), .BPC(2), .GUARD(4)) u_b2 (
    .clk(clk), .rst(rst), .load(load_v[1]), .in0(in0), .in1(in1),
    .signed_mode(signed_mode), .acc_mode(acc_mode), .in_ready(in_ready_v[1]),
    .out(out_v[1]), .valid(valid_v[1]), .out_ready(out_ready));

  shift_add_mult_pipe #(.WIDTH(8), .BPC(4), .GUARD(4)) u_b4 (
    .clk(clk), .rst(rst), .load(load_v[2]), .in0(in0), .in1(in1),
    .signed_mode(signed_mode), .acc_mode(acc_mode), .in_ready(in_ready_v[2]),
    .out(out_v[2]), .valid(valid_v[2]), .out_ready(out_ready));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          sm;
    bit          am;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Issue one op on unit u, check latency and result; optionally release it.
  task automatic run_op(input int u, input logic [7:0] a, input logic [7:0] b,
                        input bit sm, input bit am, input logic [19:0] exp,
                        input int lat, input bit release_it);
    int n;
    logic [19:0] e;
    @(negedge clk);
    chk("in_ready_before_load", {31'd0, in_ready_v[u]}, 32'd1);
    in0 = a; in1 = b; signed_mode = sm; acc_mode = am; load_v[u] = 1'b1;
    @(posedge clk);
    sb.push_back(exp);
    #1;
    load_v[u] = 1'b0;
    n = 0;
    while (!valid_v[u] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
    if (valid_v[u]) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("result", {12'd0, out_v[u]}, {12'd0, e});
      end
    end else begin
      chk("valid_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    if (release_it) begin
      @(posedge clk); #1;
      chk("release_to_idle", {30'd0, valid_v[u], in_ready_v[u]}, 32'd1);
    end
  endtask

  initial begin
    logic [19:0] run_sum;
    logic [19:0] held;

    vecs[0] = '{8'd10, 8'd12, 1'b0, 1'b0, 20'h00078};
    vecs[1] = '{8'd3,  8'd4,  1'b0, 1'b1, 20'h00084};
    vecs[2] = '{8'hFD, 8'h05, 1'b1, 1'b0, 20'hFFFF1};
    vecs[3] = '{8'h80, 8'h80, 1'b1, 1'b0, 20'h04000};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 20'h0FE01};
    vecs[5] = '{8'h7F, 8'h80, 1'b1, 1'b0, 20'hFC080};
    vecs[6] = '{8'h00, 8'hFF, 1'b1, 1'b0, 20'h00000};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 20'h00001};

    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk("reset_out",      {12'd0, out_v[u]}, 32'd0);
      chk("reset_flags",    {30'd0, valid_v[u], in_ready_v[u]}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 8; i++) begin
        run_op(u, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].am, vecs[i].exp, 8 >> u, 1'b1);
      end
    end

    // Accumulate wrap: clear with 0*0, then 255*255 eighteen times.
    run_op(0, 8'd0, 8'd0, 1'b0, 1'b0, 20'h0, 8, 1'b1);
    run_sum = '0;
    for (int i = 0; i < 18; i++) begin
      run_sum = run_sum + 20'd65025;
      run_op(0, 8'hFF, 8'hFF, 1'b0, 1'b1, run_sum, 8, 1'b1);
    end
    chk("acc_wrap_final", {12'd0, out_v[0]}, 32'h1DC12);

    // Backpressure: result held while load pulses are ignored.
    out_ready = 1'b0;
    run_op(0, 8'd7, 8'd9, 1'b0, 1'b0, 20'h0003F, 8, 1'b0);
    held = out_v[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in0 = 8'h11; in1 = 8'h22; acc_mode = 1'b1; load_v[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid_held", {31'd0, valid_v[0]}, 32'd1);
      chk("bp_out_stable", {12'd0, out_v[0]}, {12'd0, held});
      chk("bp_in_ready_low", {31'd0, in_ready_v[0]}, 32'd0);
    end
    @(negedge clk);
    load_v[0] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", {30'd0, valid_v[0], in_ready_v[0]}, 32'd1);
    chk("bp_out_kept", {12'd0, out_v[0]}, 32'h0003F);

    // Async reset three edges into an operation.
    @(negedge clk);
    in0 = 8'd10; in1 = 8'd12; signed_mode = 1'b0; acc_mode = 1'b1; load_v[0] = 1'b1;
    @(posedge clk); #1;
    load_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_out", {12'd0, out_v[0]}, 32'd0);
    chk("rst_async_flags", {30'd0, valid_v[0], in_ready_v[0]}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op(1, 8'd10, 8'd12, 1'b0, 1'b1, 20'h00078, 4, 1'b1);
    run_op(0, 8'd10, 8'd12, 1'b0, 1'b1, 20'h00078, 8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_add_mult_pipe.md
Name: shift_add_mult_pipe

Overview:
- Parametrised sequential shift-and-add multiplier; successor to generic_multiplier.
- Adds signed/unsigned mode, configurable bits retired per cycle (radix 2^BPC), multiply-accumulate mode, and a ready/valid handshake with output backpressure.
- Sits as a shared arithmetic unit behind a requester; one operation in flight.

Parameters:
- WIDTH, 128, operand width in bits.
- BPC, 1, multiplier bits retired per cycle; legal 1, 2, 4; WIDTH % BPC == 0.
- GUARD, 8, accumulator guard bits above 2*WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  request; accepted on a rising edge where load && in_ready.
- in0  in  WIDTH  multiplicand.
- in1  in  WIDTH  multiplier.
- signed_mode  in  1  1: operands two's complement; sampled on accept.
- acc_mode  in  1  1: add product to current out; 0: out = product; sampled on accept.
- in_ready  out  1  block idle, can accept.
- out  out  2*WIDTH+GUARD  result / accumulator register.
- valid  out  1  out holds a fresh result.
- out_ready  in  1  consumer takes result.

Behaviour:
- Reset (async, any state): state=IDLE, out=0, valid=0, in_ready=1, counter and operand registers cleared. A reset mid-operation discards the operation; the accumulator is lost.
- Let CYC = WIDTH/BPC and OW = 2*WIDTH+GUARD.
- States:
  - IDLE: in_ready=1, valid=0. On accept: latch |in0|, |in1| (magnitude when signed_mode, else raw), the result sign (in0[MSB]^in1[MSB] when signed_mode, else 0), acc_mode, clear the partial product, set count=CYC, and go to BUSY.
  - BUSY: in_ready=0. On each edge, add multiplicand * low BPC bits of the multiplier to the partial product (shifted), shift the multiplier right BPC, and decrement count.
  - BUSY, on the edge where count reaches 0: apply the sign, sign-extend (signed) or zero-extend (unsigned) to OW, out <= (acc ? out : 0) + product mod 2^OW, then go to DONE.
  - DONE: valid=1 and out stable. On the edge with out_ready=1, go to IDLE and valid=0. out keeps its value in IDLE (it is the accumulator).
- Latency: accept at edge k; valid high after edge k+CYC. Throughput: one op per CYC+2 cycles with out_ready held high.
- load while in_ready=0 is ignored, with no queueing; load and operands are don't-care then.
- Operands are sampled only on accept; later changes on in0/in1 have no effect.
- Signed WIDTH-bit minimum (-2^(WIDTH-1)): the magnitude 2^(WIDTH-1) fits unsigned WIDTH bits, so the product is correct.
- Accumulate overflow wraps modulo 2^OW with no saturation and no flag.
- out_ready while not DONE: ignored.

Decomposition:
- Package shift_add_mult_pkg: state enum (IDLE, BUSY, DONE); localparams CYC and OW as functions of WIDTH/BPC/GUARD; a BPC legality check (elaboration error if illegal).
- One natural sub-module: mult_step_unit, combinational. Inputs are the partial product, multiplicand, and BPC multiplier bits; output is the next partial product.
- FSM, counter, sign handling and accumulator stay in the top.

Test Plan (WIDTH=8, GUARD=4, OW=20 unless noted):
- Unsigned: in0=10, in1=12, signed_mode=0, acc_mode=0 → valid after 8 edges; out=0x00078 (120).
- Signed: in0=0xFD (-3), in1=0x05, signed_mode=1 → out=0xFFFF1 (-15). Also in0=0x80, in1=0x80 → out=0x04000 (16384).
- Unsigned max: in0=in1=0xFF → out=0x0FE01.
- Accumulate: 10*12 (acc_mode=0), then 3*4 (acc_mode=1) → second out=0x00084 (132). Repeat 255*255 with acc_mode=1 eighteen times → out wraps to (18*65025) mod 2^20 = 0x1DC12.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing load with new operands. Required: valid=1, out unchanged, in_ready=0, new request not accepted. Raise out_ready → IDLE next edge.
- Reset/BPC: assert rst 3 edges after accept → valid=0, in_ready=1, out=0 immediately (async). Rebuild with BPC=2: 10*12 → out=120 after 4 edges. BPC=4 → after 2 edges.
